// File: rtl/player_sprite_fetch_pkg.sv
// Shared types and sprite geometry for the player sprite fetch stage.
// The alien and bullet fetch stages reuse the same geometry helpers.
package player_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        BLINK = 2'd1,
        DEAD  = 2'd2
    } player_state_t;

    localparam int SPRITE_W    = 48;
    localparam int SPRITE_H    = 30;
    localparam int ADDR_W      = 19;
    localparam int PIX_W       = 5;
    localparam int TRANSPARENT = 0;

endpackage

// File: rtl/player_sprite_fetch_if.sv
// Read-side bus between the sprite fetch stage and the sprite RAM.
// The fetch stage drives the address; the RAM returns registered data.
interface player_sprite_fetch_if #(
    parameter int ADDR_W = player_pkg::ADDR_W,
    parameter int PIX_W  = player_pkg::PIX_W
);
    logic [ADDR_W-1:0] sprite_read_address;
    logic [PIX_W-1:0]  sprite_data;

    modport master (output sprite_read_address, input sprite_data);
    modport slave  (input sprite_read_address, output sprite_data);
endinterface

// File: rtl/player_sprite_fetch_addr_gen.sv
// Combinational sprite bounding-box test and row-major RAM address.
// Returns address 0 outside the box so the RAM never sees an out-of-range index.
module sprite_addr_gen #(
    parameter int SPRITE_W = player_pkg::SPRITE_W,
    parameter int SPRITE_H = player_pkg::SPRITE_H,
    parameter int ADDR_W   = player_pkg::ADDR_W
) (
    input  logic [9:0]        i_draw_x,
    input  logic [9:0]        i_draw_y,
    input  logic [9:0]        i_pos_x,
    input  logic [9:0]        i_pos_y,
    output logic              o_in_box,
    output logic [ADDR_W-1:0] o_addr
);
    import player_pkg::*;

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;

    // One extra bit keeps pos+size from wrapping near the right/bottom edge.
    assign w_x  = {1'b0, i_draw_x};
    assign w_y  = {1'b0, i_draw_y};
    assign w_px = {1'b0, i_pos_x};
    assign w_py = {1'b0, i_pos_y};

    assign o_in_box = (w_x >= w_px) && (w_x < w_px + 11'(SPRITE_W)) &&
                      (w_y >= w_py) && (w_y < w_py + 11'(SPRITE_H));

    assign w_dx = i_draw_x - i_pos_x;
    assign w_dy = i_draw_y - i_pos_y;

    assign o_addr = o_in_box ? (ADDR_W'(w_dy) * ADDR_W'(SPRITE_W) + ADDR_W'(w_dx))
                             : '0;
endmodule

// File: rtl/player_sprite_fetch.sv
// Player sprite pixel pipeline: address generation, RAM read alignment and
// hit/blink/dead visibility gating. Three cycles from DrawX/DrawY to pixel out.
module player_sprite_fetch
    import player_pkg::*;
#(
    parameter int SPRITE_W     = player_pkg::SPRITE_W,
    parameter int SPRITE_H     = player_pkg::SPRITE_H,
    parameter int ADDR_W       = player_pkg::ADDR_W,
    parameter int PIX_W        = player_pkg::PIX_W,
    parameter int TRANSPARENT  = player_pkg::TRANSPARENT,
    parameter int BLINK_FRAMES = 16,
    parameter int BLINK_PERIOD = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic [9:0]           player_x,
    input  logic [9:0]           player_y,
    input  logic                 hit,
    input  logic                 lives_zero,
    input  logic                 respawn,
    player_sprite_fetch_if.master ram,
    output logic [PIX_W-1:0]     pixel_index,
    output logic                 pixel_on,
    output logic [1:0]           player_state
);
    localparam int CNT_W = $clog2(BLINK_FRAMES);
    localparam logic [1:0] ST_ALIVE = 2'(ALIVE);
    localparam logic [1:0] ST_BLINK = 2'(BLINK);
    localparam logic [1:0] ST_DEAD  = 2'(DEAD);

    logic [9:0]        r_px;
    logic [9:0]        r_py;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [ADDR_W-1:0] r_addr_p1;
    logic              r_in_box_p1;
    logic              r_in_box_p2;
    logic [PIX_W-1:0]  r_pix_p3;
    logic              r_on_p3;

    logic              w_in_box;
    logic [ADDR_W-1:0] w_addr;
    logic              w_visible;
    logic              w_last_frame;

    // Position only moves at frame boundaries so a frame is never torn.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_px <= '0;
            r_py <= '0;
        end else if (frame_start) begin
            r_px <= player_x;
            r_py <= player_y;
        end
    end

    assign w_last_frame = (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_ALIVE;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (hit) begin
                        r_state     <= ST_BLINK;
                        r_frame_cnt <= '0;
                    end
                end
                ST_BLINK: begin
                    if (frame_start) begin
                        if (w_last_frame) begin
                            r_state     <= lives_zero ? ST_DEAD : ST_ALIVE;
                            r_frame_cnt <= '0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (respawn) r_state <= ST_ALIVE;
                end
                default: r_state <= ST_ALIVE;
            endcase
        end
    end

    always_comb begin
        w_visible = 1'b0;
        case (r_state)
            ST_ALIVE: w_visible = 1'b1;
            ST_BLINK: w_visible = ((r_frame_cnt / CNT_W'(BLINK_PERIOD)) % CNT_W'(2)) == '0;
            default:  w_visible = 1'b0;
        endcase
    end

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .i_pos_x  (r_px),
        .i_pos_y  (r_py),
        .o_in_box (w_in_box),
        .o_addr   (w_addr)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr_p1   <= '0;
            r_in_box_p1 <= 1'b0;
            r_in_box_p2 <= 1'b0;
            r_pix_p3    <= '0;
            r_on_p3     <= 1'b0;
        end else begin
            // Stage 1: address to RAM
            r_addr_p1   <= w_addr;
            r_in_box_p1 <= w_in_box;
            // Stage 2: RAM registers its read; hit flag follows
            r_in_box_p2 <= r_in_box_p1;
            // Stage 3: palette index and opacity/visibility gate
            r_pix_p3    <= ram.sprite_data;
            r_on_p3     <= r_in_box_p2 && (ram.sprite_data != PIX_W'(TRANSPARENT)) && w_visible;
        end
    end

    assign ram.sprite_read_address = r_addr_p1;
    assign pixel_index  = r_pix_p3;
    assign pixel_on     = r_on_p3;
    assign player_state = r_state;
endmodule
